// File: rtl/output_deskewer.sv
// Realigns staggered systolic-array column sums into whole rows and tracks rows per frame.
// Optional DESKEW_OVERRUN_EN: drop rows that complete after done and flag a sticky overrun.

module deskew_lane #(
  parameter int DEPTH = 1,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [DEPTH-1:0][W-1:0] dly_q, dly_d;

  always_comb begin
    dly_d = dly_q;
    if (enable) begin
      dly_d[0] = din;
      for (int j = 1; j < DEPTH; j++) dly_d[j] = dly_q[j-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dly_q <= '0;
    else        dly_q <= dly_d;
  end

  assign dout = dly_q[DEPTH-1];
endmodule

module output_deskewer #(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  enable,
  input  logic                                  start,
  input  logic                                  in_valid,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] sum_skewed,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] result_row,
  output logic                                  row_valid,
  output logic [$clog2(MATRIX_SIZE)-1:0]        row_index,
`ifdef DESKEW_OVERRUN_EN
  output logic                                  overrun,
`endif
  output logic                                  done
);
  localparam int N  = MATRIX_SIZE;
  localparam int IW = $clog2(MATRIX_SIZE);
  localparam logic [IW-1:0] LAST = IW'(MATRIX_SIZE - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t                      state_q, state_d;
  logic [IW-1:0]               cnt_q, cnt_d;
  logic [N-1:1]                vld_q, vld_d;
  logic [N-1:0][DATA_SIZE-1:0] lane_out;
  logic [N-1:0][DATA_SIZE-1:0] result_q, result_d;
  logic                        row_valid_q, row_valid_d;
  logic [IW-1:0]               row_index_q, row_index_d;
`ifdef DESKEW_OVERRUN_EN
  logic                        overrun_q, overrun_d;
`endif

  // Lane i waits N-1-i cycles so it lines up with the last lane, which arrives undelayed.
  for (genvar i = 0; i < N - 1; i++) begin : g_lane
    deskew_lane #(.DEPTH(N - 1 - i), .W(DATA_SIZE)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .din    (sum_skewed[i]),
      .dout   (lane_out[i])
    );
  end
  assign lane_out[N-1] = sum_skewed[N-1];

  always_comb begin
    vld_d       = vld_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    row_index_d = row_index_q;
    row_valid_d = 1'b0;
`ifdef DESKEW_OVERRUN_EN
    overrun_d   = overrun_q;
`endif
    if (enable) begin
      vld_d[1] = in_valid;
      for (int j = 2; j < N; j++) vld_d[j] = vld_q[j-1];
      // start takes effect before any row completing on this same edge is counted
      if (start) begin
        state_d = IDLE;
        cnt_d   = '0;
`ifdef DESKEW_OVERRUN_EN
        overrun_d = 1'b0;
`endif
      end
      if (vld_q[N-1]) begin
        if (state_d == DONE) begin
`ifdef DESKEW_OVERRUN_EN
          overrun_d = 1'b1;
`else
          row_valid_d = 1'b1;
          result_d    = lane_out;
          row_index_d = LAST;
`endif
        end else begin
          row_valid_d = 1'b1;
          result_d    = lane_out;
          row_index_d = cnt_d;
          if (cnt_d == LAST) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_d + 1'b1;
            state_d = COLLECT;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vld_q       <= '0;
      result_q    <= '0;
      row_valid_q <= 1'b0;
      row_index_q <= '0;
`ifdef DESKEW_OVERRUN_EN
      overrun_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vld_q       <= vld_d;
      result_q    <= result_d;
      row_valid_q <= row_valid_d;
      row_index_q <= row_index_d;
`ifdef DESKEW_OVERRUN_EN
      overrun_q   <= overrun_d;
`endif
    end
  end

  assign result_row = result_q;
  assign row_valid  = row_valid_q;
  assign row_index  = row_index_q;
  assign done       = (state_q == DONE);
`ifdef DESKEW_OVERRUN_EN
  assign overrun    = overrun_q;
`endif
endmodule

// File: tb/tb_output_deskewer.sv
// Directed, table-driven bench for output_deskewer with N=2, 32-bit lanes.
module tb_output_deskewer;
  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            enable = 1'b1;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic [1:0][31:0] sum_skewed = '0;
  logic [1:0][31:0] result_row;
  logic            row_valid;
  logic            row_index;
  logic            done;
  logic            overrun;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

`ifndef DESKEW_OVERRUN_EN
  assign overrun = 1'b0;
`endif

  output_deskewer #(.MATRIX_SIZE(2), .DATA_SIZE(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .start      (start),
    .in_valid   (in_valid),
    .sum_skewed (sum_skewed),
    .result_row (result_row),
    .row_valid  (row_valid),
    .row_index  (row_index),
`ifdef DESKEW_OVERRUN_EN
    .overrun    (overrun),
`endif
    .done       (done)
  );

  typedef struct {
    logic        st, iv, en;
    logic [31:0] l0, l1;
    logic        rv, dn, ov;
    logic        chk;
    logic [31:0] r0, r1;
    logic        idx;
  } vec_t;

  vec_t tv[32];
  int   nv = 0;

  task automatic add(input logic st, iv, en, input logic [31:0] l0, l1,
                     input logic rv, dn, ov, chk, input logic [31:0] r0, r1,
                     input logic idx);
    tv[nv] = '{st:st, iv:iv, en:en, l0:l0, l1:l1, rv:rv, dn:dn, ov:ov,
               chk:chk, r0:r0, r1:r1, idx:idx};
    nv++;
  endtask

  task automatic check(input string name, input logic [127:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, iv, en, input logic [31:0] l0, l1);
    start = st; in_valid = iv; enable = en;
    sum_skewed[0] = l0; sum_skewed[1] = l1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_outs(input string name, input logic rv, dn, ov, chk,
                            input logic [31:0] r0, r1, input logic idx);
    check({name, " flags"}, {125'd0, row_valid, done, overrun}, {125'd0, rv, dn, ov});
    if (chk)
      check({name, " row"}, {63'd0, row_index, result_row[1], result_row[0]},
            {63'd0, idx, r1, r0});
  endtask

  logic ovx;

  initial begin
`ifdef DESKEW_OVERRUN_EN
    ovx = 1'b1;
`else
    ovx = 1'b0;
`endif
    //   st iv en l0     l1      rv dn ov chk r0    r1    idx
    // T1 basic frame
    add(1, 1, 1, 32'h11, 32'h00, 0, 0, 0, 1, 32'h0, 32'h0, 0);
    add(0, 1, 1, 32'h12, 32'h21, 1, 0, 0, 1, 32'h11, 32'h21, 0);
    add(0, 0, 1, 32'h00, 32'h22, 1, 1, 0, 1, 32'h12, 32'h22, 1);
    add(0, 0, 1, 32'h00, 32'h00, 0, 1, 0, 1, 32'h12, 32'h22, 1);
    // T5 third row after done
    add(0, 1, 1, 32'h33, 32'h00, 0, 1, 0, 0, 32'h0, 32'h0, 0);
    if (ovx) add(0, 0, 1, 32'h00, 32'h44, 0, 1, 1, 1, 32'h12, 32'h22, 1);
    else     add(0, 0, 1, 32'h00, 32'h44, 1, 1, 0, 1, 32'h33, 32'h44, 1);
    // T2 stall for 3 cycles after edge1; stalled lane values must be ignored
    add(1, 1, 1, 32'h11, 32'h00, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    add(0, 1, 1, 32'h12, 32'h21, 1, 0, 0, 1, 32'h11, 32'h21, 0);
    add(0, 1, 0, 32'hDEAD, 32'hBEEF, 0, 0, 0, 1, 32'h11, 32'h21, 0);
    add(0, 0, 0, 32'hDEAD, 32'hBEEF, 0, 0, 0, 1, 32'h11, 32'h21, 0);
    add(0, 1, 0, 32'hDEAD, 32'hBEEF, 0, 0, 0, 1, 32'h11, 32'h21, 0);
    add(0, 0, 1, 32'h00, 32'h22, 1, 1, 0, 1, 32'h12, 32'h22, 1);
    // T6 two frames back-to-back
    add(1, 1, 1, 32'h51, 32'h00, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    add(0, 1, 1, 32'h52, 32'h61, 1, 0, 0, 1, 32'h51, 32'h61, 0);
    add(0, 0, 1, 32'h00, 32'h62, 1, 1, 0, 1, 32'h52, 32'h62, 1);
    add(1, 1, 1, 32'h71, 32'h00, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    add(0, 1, 1, 32'h72, 32'h81, 1, 0, 0, 1, 32'h71, 32'h81, 0);
    add(0, 0, 1, 32'h00, 32'h82, 1, 1, 0, 1, 32'h72, 32'h82, 1);
    // T4 start and in_valid together while in DONE
    add(1, 1, 1, 32'h91, 32'h00, 0, 0, 0, 0, 32'h0, 32'h0, 0);
    add(0, 0, 1, 32'h00, 32'h92, 1, 0, 0, 1, 32'h91, 32'h92, 0);
    add(0, 0, 1, 32'h00, 32'h00, 0, 0, 0, 1, 32'h91, 32'h92, 0);

    drive(0, 0, 1, 0, 0);
    #12;
    check_outs("reset", 0, 0, 0, 1, 32'h0, 32'h0, 0);
    @(negedge clk); reset = 1'b1;

    for (int i = 0; i < nv; i++) begin
      drive(tv[i].st, tv[i].iv, tv[i].en, tv[i].l0, tv[i].l1);
      tick();
      check_outs($sformatf("vec%0d", i), tv[i].rv, tv[i].dn, tv[i].ov,
                 tv[i].chk, tv[i].r0, tv[i].r1, tv[i].idx);
    end

    // T3 asynchronous reset mid-frame, just after the first row emerges
    drive(1, 1, 1, 32'h11, 32'h00); tick();
    drive(0, 1, 1, 32'h12, 32'h21); tick();
    check_outs("t3 row0", 1, 0, 0, 1, 32'h11, 32'h21, 0);
    reset = 1'b0; #1;
    check_outs("t3 async", 0, 0, 0, 1, 32'h0, 32'h0, 0);
    drive(0, 0, 1, 32'h00, 32'h22); tick();
    check_outs("t3 held", 0, 0, 0, 1, 32'h0, 32'h0, 0);
    @(negedge clk); reset = 1'b1;
    drive(0, 0, 1, 32'h00, 32'h22); tick();
    check_outs("t3 flushed", 0, 0, 0, 1, 32'h0, 32'h0, 0);
    drive(1, 1, 1, 32'hA, 32'h0); tick();
    check_outs("t3 new0", 0, 0, 0, 0, 32'h0, 32'h0, 0);
    drive(0, 0, 1, 32'h0, 32'hB); tick();
    check_outs("t3 new1", 1, 0, 0, 1, 32'hA, 32'hB, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
